// File: rtl/e203_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : e203_rst_seq
// Brief    : Debounced, PLL-lock-qualified reset sequencer with cause/count.
//            Optional software reset request: define E203_RSTSEQ_SWRST_EN.
// Revision : 1.0 - initial release
// ============================================================================
module e203_rst_seq #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] DB_CYCLES   = 16'd50000,
  parameter logic [15:0] HOLD_CYCLES = 16'd16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       erstn_raw,
  input  logic       pll_lock,
`ifdef E203_RSTSEQ_SWRST_EN
  input  logic       sw_rst_req,
`endif
  output logic       sys_rst_n,
  output logic       rst_done,
  output logic [1:0] rst_cause,
  output logic [7:0] rst_cnt
);

  typedef enum logic [1:0] {
    ST_RESET     = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  localparam logic [15:0] C_DB_LAST   = DB_CYCLES - 16'd1;
  localparam logic [15:0] C_HOLD_LAST = HOLD_CYCLES - 16'd1;

  logic [SYNC_STAGES-1:0] btn_sync_q, btn_sync_d;
  logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
  logic                   btn_db_q, btn_db_d;
  logic [15:0]            db_cnt_q, db_cnt_d;
  logic [15:0]            hold_cnt_q, hold_cnt_d;
  state_t                 state_q, state_d;
  logic                   sys_rst_n_q, sys_rst_n_d;
  logic                   rst_done_q, rst_done_d;
  logic [1:0]             rst_cause_q, rst_cause_d;
  logic [7:0]             rst_cnt_q, rst_cnt_d;
  logic                   btn_s, lock_s, sw_req;

  assign btn_s  = btn_sync_q[SYNC_STAGES-1];
  assign lock_s = lock_sync_q[SYNC_STAGES-1];

`ifdef E203_RSTSEQ_SWRST_EN
  assign sw_req = sw_rst_req;
`else
  assign sw_req = 1'b0;
`endif

  always_comb begin
    btn_sync_d  = {btn_sync_q[SYNC_STAGES-2:0], erstn_raw};
    lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], pll_lock};
  end

  // A change on btn_s must persist DB_CYCLES consecutive cycles to be accepted.
  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = db_cnt_q;
    if (btn_s == btn_db_q) begin
      db_cnt_d = 16'd0;
    end else if (db_cnt_q == C_DB_LAST) begin
      btn_db_d = btn_s;
      db_cnt_d = 16'd0;
    end else begin
      db_cnt_d = db_cnt_q + 16'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    rst_cause_d = rst_cause_q;
    rst_cnt_d   = rst_cnt_q;
    unique case (state_q)
      ST_RESET: begin
        if (btn_db_q) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (!btn_db_q) begin
          state_d = ST_RESET;
        end else if (lock_s) begin
          state_d    = ST_HOLD;
          hold_cnt_d = 16'd0;
        end
      end
      ST_HOLD: begin
        if (!btn_db_q)                      state_d = ST_RESET;
        else if (!lock_s)                   state_d = ST_WAIT_LOCK;
        else if (hold_cnt_q == C_HOLD_LAST) state_d = ST_RUN;
        else                                hold_cnt_d = hold_cnt_q + 16'd1;
      end
      ST_RUN: begin
        // Button wins over lock loss, which wins over a software request.
        if (!btn_db_q) begin
          state_d     = ST_RESET;
          rst_cause_d = 2'b01;
        end else if (!lock_s) begin
          state_d     = ST_WAIT_LOCK;
          rst_cause_d = 2'b10;
        end else if (sw_req) begin
          state_d     = ST_HOLD;
          hold_cnt_d  = 16'd0;
          rst_cause_d = 2'b11;
        end
      end
      default: state_d = ST_RESET;
    endcase

    if (state_q == ST_RUN && state_d != ST_RUN && rst_cnt_q != 8'hFF)
      rst_cnt_d = rst_cnt_q + 8'd1;

    sys_rst_n_d = (state_d == ST_RUN);
    rst_done_d  = (state_q == ST_HOLD) && (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_sync_q  <= '0;
      lock_sync_q <= '0;
      btn_db_q    <= 1'b0;
      db_cnt_q    <= 16'd0;
      hold_cnt_q  <= 16'd0;
      state_q     <= ST_RESET;
      sys_rst_n_q <= 1'b0;
      rst_done_q  <= 1'b0;
      rst_cause_q <= 2'b00;
      rst_cnt_q   <= 8'd0;
    end else begin
      btn_sync_q  <= btn_sync_d;
      lock_sync_q <= lock_sync_d;
      btn_db_q    <= btn_db_d;
      db_cnt_q    <= db_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      state_q     <= state_d;
      sys_rst_n_q <= sys_rst_n_d;
      rst_done_q  <= rst_done_d;
      rst_cause_q <= rst_cause_d;
      rst_cnt_q   <= rst_cnt_d;
    end
  end

  assign sys_rst_n = sys_rst_n_q;
  assign rst_done  = rst_done_q;
  assign rst_cause = rst_cause_q;
  assign rst_cnt   = rst_cnt_q;

endmodule
`default_nettype wire
